// File: rtl/m2_write_arbiter.sv
// Round-robin arbiter for the single M2 scratchpad write port, with lock for RMW bursts.
// Optional bank-clear sweep engine enabled by defining M2_SWEEP_CLEAR_EN.
module m2_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 20,
    parameter int BINS   = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ-1:0]          wr_en,
    input  logic [NREQ*ADDR_W-1:0]   wr_addr,
    input  logic [NREQ*DATA_W-1:0]   wr_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     M2_WriteEnable,
    output logic [ADDR_W-1:0]        M2_WriteAddress,
    output logic [DATA_W-1:0]        M2_WriteBus,
    output logic                     protocol_err,
    input  logic                     clear_start,
    input  logic                     clear_bank,
    output logic                     clear_busy,
    output logic                     clear_done
);

`ifdef M2_SWEEP_CLEAR_EN
    localparam int NSLOT = NREQ + 1;
`else
    localparam int NSLOT = NREQ;
`endif
    localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int CW = (BINS > 1) ? $clog2(BINS) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

    state_t            state_r;
    logic [NSLOT-1:0]  gnt_r;
    logic [PW-1:0]     ptr_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic              perr_r;

    logic [NSLOT-1:0]  req_all_s;
    logic [NSLOT-1:0]  lock_all_s;
    logic [NSLOT-1:0]  wen_all_s;
    logic [ADDR_W-1:0] addr_all_s [NSLOT];
    logic [DATA_W-1:0] data_all_s [NSLOT];
    logic              found_s;
    logic [PW-1:0]     win_s;
    logic [PW-1:0]     ptr_next_s;
    logic              hold_s;
    logic              sel_wen_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;

`ifdef M2_SWEEP_CLEAR_EN
    logic              clear_busy_r;
    logic              clear_last_r;
    logic              clear_done_r;
    logic              clear_bank_r;
    logic [CW-1:0]     clear_cnt_r;
    logic              clear_final_s;
    logic              clear_req_s;

    // The sweep's own request drops on the edge that issues its last write, so the grant lasts exactly BINS cycles.
    assign clear_final_s = gnt_r[NREQ] & (clear_cnt_r == CW'(BINS - 1));
    assign clear_req_s   = clear_busy_r & ~clear_last_r & ~clear_final_s;

    // Clear engine: latch the bank, count bins while granted, then report completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_busy_r <= 1'b0;
            clear_last_r <= 1'b0;
            clear_done_r <= 1'b0;
            clear_bank_r <= 1'b0;
            clear_cnt_r  <= {CW{1'b0}};
        end else begin
            clear_done_r <= 1'b0;
            if (!clear_busy_r) begin
                if (clear_start) begin
                    clear_busy_r <= 1'b1;
                    clear_bank_r <= clear_bank;
                    clear_cnt_r  <= {CW{1'b0}};
                end
            end else if (clear_last_r) begin
                clear_busy_r <= 1'b0;
                clear_last_r <= 1'b0;
                clear_done_r <= 1'b1;
            end else if (gnt_r[NREQ]) begin
                clear_cnt_r  <= clear_final_s ? {CW{1'b0}} : clear_cnt_r + CW'(1);
                clear_last_r <= clear_final_s;
            end
        end
    end

    assign clear_busy = clear_busy_r;
    assign clear_done = clear_done_r;
`else
    logic unused_clear_s;
    assign unused_clear_s = clear_start ^ clear_bank;
    assign clear_busy     = 1'b0;
    assign clear_done     = 1'b0;
`endif

    // Gather external requesters (and the clear slot when present) into uniform per-slot vectors.
    always_comb begin
        req_all_s  = {NSLOT{1'b0}};
        lock_all_s = {NSLOT{1'b0}};
        wen_all_s  = {NSLOT{1'b0}};
        for (int s = 0; s < NSLOT; s++) begin
            addr_all_s[s] = {ADDR_W{1'b0}};
            data_all_s[s] = {DATA_W{1'b0}};
        end
        req_all_s[NREQ-1:0]  = req;
        lock_all_s[NREQ-1:0] = lock;
        wen_all_s[NREQ-1:0]  = wr_en;
        for (int i = 0; i < NREQ; i++) begin
            addr_all_s[i] = wr_addr[i*ADDR_W +: ADDR_W];
            data_all_s[i] = wr_data[i*DATA_W +: DATA_W];
        end
`ifdef M2_SWEEP_CLEAR_EN
        req_all_s[NREQ]  = clear_req_s;
        lock_all_s[NREQ] = clear_req_s;
        wen_all_s[NREQ]  = gnt_r[NREQ];
        addr_all_s[NREQ] = ADDR_W'({clear_bank_r, clear_cnt_r});
`endif
    end

    // Round-robin search starting at ptr_r; first requesting slot in rotated order wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        for (int k = 0; k < NSLOT; k++) begin
            int idx_v;
            idx_v   = (int'(ptr_r) + k) % NSLOT;
            win_s   = (req_all_s[idx_v] & ~found_s) ? PW'(idx_v) : win_s;
            found_s = found_s | req_all_s[idx_v];
        end
        ptr_next_s = (win_s == PW'(NSLOT - 1)) ? {PW{1'b0}} : win_s + PW'(1);
        hold_s     = |(gnt_r & (req_all_s | lock_all_s));
    end

    // One-hot grant selects the write that gets registered toward M2.
    always_comb begin
        sel_wen_s  = |(gnt_r & wen_all_s);
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        for (int s = 0; s < NSLOT; s++) begin
            sel_addr_s = sel_addr_s | (addr_all_s[s] & {ADDR_W{gnt_r[s]}});
            sel_data_s = sel_data_s | (data_all_s[s] & {DATA_W{gnt_r[s]}});
        end
    end

    // Arbitration FSM with registered one-hot grant; release always passes through IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            gnt_r   <= {NSLOT{1'b0}};
            ptr_r   <= {PW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r <= ST_GRANT;
                        gnt_r   <= {{(NSLOT-1){1'b0}}, 1'b1} << win_s;
                        ptr_r   <= ptr_next_s;
                    end
                end
                ST_GRANT: begin
                    if (!hold_s) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= {NSLOT{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {NSLOT{1'b0}};
                end
            endcase
        end
    end

    // M2 write register and sticky error for strobes from non-granted requesters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_r   <= 1'b0;
            addr_r <= {ADDR_W{1'b0}};
            data_r <= {DATA_W{1'b0}};
            perr_r <= 1'b0;
        end else begin
            we_r   <= sel_wen_s;
            perr_r <= perr_r | (|(wr_en & ~gnt_r[NREQ-1:0]));
            if (|gnt_r) begin
                addr_r <= sel_addr_s;
                data_r <= sel_data_s;
            end
        end
    end

    assign gnt             = gnt_r[NREQ-1:0];
    assign M2_WriteEnable  = we_r;
    assign M2_WriteAddress = addr_r;
    assign M2_WriteBus     = data_r;
    assign protocol_err    = perr_r;

endmodule

// File: tb/tb_m2_write_arbiter.sv
// Self-checking bench for m2_write_arbiter: scoreboard of expected M2 writes plus direct grant checks.
module tb_m2_write_arbiter;
    localparam int NREQ   = 3;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 20;
    localparam int BINS   = 256;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        lock = '0;
    logic [NREQ-1:0]        wr_en = '0;
    logic [NREQ*ADDR_W-1:0] wr_addr = '0;
    logic [NREQ*DATA_W-1:0] wr_data = '0;
    logic [NREQ-1:0]        gnt;
    logic                   M2_WriteEnable;
    logic [ADDR_W-1:0]      M2_WriteAddress;
    logic [DATA_W-1:0]      M2_WriteBus;
    logic                   protocol_err;
    logic                   clear_start = 1'b0;
    logic                   clear_bank = 1'b0;
    logic                   clear_busy;
    logic                   clear_done;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q [$];

    m2_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BINS(BINS)) dut (
        .clock(clock), .reset(reset), .req(req), .lock(lock), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .gnt(gnt),
        .M2_WriteEnable(M2_WriteEnable), .M2_WriteAddress(M2_WriteAddress),
        .M2_WriteBus(M2_WriteBus), .protocol_err(protocol_err),
        .clear_start(clear_start), .clear_bank(clear_bank),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_addr[i*ADDR_W +: ADDR_W] = a;
        wr_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every M2 write must match the oldest expected write.
    always @(negedge clock) begin
        if (!reset && M2_WriteEnable) begin
            logic [ADDR_W+DATA_W-1:0] e;
            check_val("m2_write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("m2_addr", 32'(M2_WriteAddress), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check_val("m2_data", 32'(M2_WriteBus), 32'(e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step();
        check_val("rst_gnt", 32'(gnt), 32'd0);
        check_val("rst_we", 32'(M2_WriteEnable), 32'd0);
        check_val("rst_addr", 32'(M2_WriteAddress), 32'd0);
        check_val("rst_bus", 32'(M2_WriteBus), 32'd0);
        check_val("rst_perr", 32'(protocol_err), 32'd0);
        check_val("rst_busy", 32'(clear_busy), 32'd0);
        check_val("rst_done", 32'(clear_done), 32'd0);
        step();
        reset = 1'b0;

        // Single requester: grant one cycle after req, write one cycle after strobe.
        step();
        req = 3'b001;
        check_val("t1_no_comb_gnt", 32'(gnt), 32'd0);
        step();
        check_val("t1_gnt", 32'(gnt), 32'b001);
        wr_en = 3'b001;
        set_wr(0, 9'h005, 20'd7);
        push_exp(9'h005, 20'd7);
        step();
        check_val("t1_we", 32'(M2_WriteEnable), 32'd1);
        check_val("t1_addr", 32'(M2_WriteAddress), 32'h005);
        check_val("t1_bus", 32'(M2_WriteBus), 32'd7);
        wr_en = 3'b000;
        step();
        check_val("t1_we_off", 32'(M2_WriteEnable), 32'd0);
        req = 3'b000;
        step();
        check_val("t1_release", 32'(gnt), 32'd0);

        // Contention from reset: 0 first, idle gap, then 1, no preemption.
        req = 3'b011;
        do_reset();
        step();
        check_val("t2_first", 32'(gnt), 32'b001);
        step();
        check_val("t2_hold", 32'(gnt), 32'b001);
        req = 3'b010;
        step();
        check_val("t2_idle", 32'(gnt), 32'd0);
        step();
        check_val("t2_second", 32'(gnt), 32'b010);
        req = 3'b011;
        wr_en = 3'b010;
        set_wr(1, 9'h1AB, 20'hABCDE);
        push_exp(9'h1AB, 20'hABCDE);
        step();
        check_val("t2_no_preempt", 32'(gnt), 32'b010);
        wr_en = 3'b000;
        req = 3'b001;
        step();
        check_val("t2_idle2", 32'(gnt), 32'd0);
        step();
        check_val("t2_regrant0", 32'(gnt), 32'b001);
        req = 3'b000;
        step();

        // Three-way round robin: order 0,1,2,0 even when 0 keeps requesting.
        req = 3'b111;
        do_reset();
        step();
        check_val("rr_g0", 32'(gnt), 32'b001);
        req = 3'b110;
        step();
        check_val("rr_idle_a", 32'(gnt), 32'd0);
        step();
        check_val("rr_g1", 32'(gnt), 32'b010);
        req = 3'b101;
        step();
        check_val("rr_idle_b", 32'(gnt), 32'd0);
        step();
        check_val("rr_g2", 32'(gnt), 32'b100);
        req = 3'b011;
        step();
        check_val("rr_idle_c", 32'(gnt), 32'd0);
        step();
        check_val("rr_g0_again", 32'(gnt), 32'b001);
        req = 3'b000;
        step();

        // Lock keeps grant 1 after its req drops; 0 is granted two cycles after lock falls.
        req = 3'b010;
        step();
        check_val("t3_g1", 32'(gnt), 32'b010);
        req = 3'b011;
        lock = 3'b010;
        step();
        check_val("t3_hold_a", 32'(gnt), 32'b010);
        req = 3'b001;
        step();
        check_val("t3_lock_a", 32'(gnt), 32'b010);
        step();
        check_val("t3_lock_b", 32'(gnt), 32'b010);
        lock = 3'b000;
        step();
        check_val("t3_idle", 32'(gnt), 32'd0);
        step();
        check_val("t3_g0", 32'(gnt), 32'b001);

        // Protocol error: strobe from non-granted requester 1 is dropped and sticks the error.
        wr_en = 3'b011;
        set_wr(0, 9'h033, 20'h00011);
        set_wr(1, 9'h0FF, 20'h00022);
        push_exp(9'h033, 20'h00011);
        step();
        check_val("t4_we", 32'(M2_WriteEnable), 32'd1);
        check_val("t4_addr", 32'(M2_WriteAddress), 32'h033);
        check_val("t4_perr", 32'(protocol_err), 32'd1);
        wr_en = 3'b010;
        step();
        check_val("t4_dropped", 32'(M2_WriteEnable), 32'd0);
        wr_en = 3'b000;
        step();
        check_val("t4_sticky", 32'(protocol_err), 32'd1);
        check_val("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-grant, before the pending strobe is registered.
        wr_en = 3'b001;
        set_wr(0, 9'h044, 20'h00055);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_mid_gnt", 32'(gnt), 32'd0);
        check_val("rst_mid_perr", 32'(protocol_err), 32'd0);
        check_val("rst_mid_addr", 32'(M2_WriteAddress), 32'd0);
        check_val("rst_mid_bus", 32'(M2_WriteBus), 32'd0);
        wr_en = 3'b000;
        req = 3'b000;
        do_reset();
        step();
        check_val("rst_mid_we", 32'(M2_WriteEnable), 32'd0);

`ifdef M2_SWEEP_CLEAR_EN
        // Bank-1 clear sweep; req[0] raised mid-sweep waits for the sweep to finish.
        begin
            logic seen_done;
            seen_done = 1'b0;
            clear_bank = 1'b1;
            clear_start = 1'b1;
            step();
            clear_start = 1'b0;
            check_val("t5_busy", 32'(clear_busy), 32'd1);
            for (int b = 0; b < BINS; b++) push_exp(ADDR_W'(BINS + b), 20'd0);
            for (int i = 0; i < 400 && !seen_done; i++) begin
                step();
                clear_start = (i == 20);
                clear_bank = (i == 20) ? 1'b0 : clear_bank;
                if (i == 10) req = 3'b001;
                if (clear_done) seen_done = 1'b1;
                else check_val("t5_gnt_blocked", 32'(gnt), 32'd0);
            end
            check_val("t5_done_seen", 32'(seen_done), 32'd1);
            check_val("t5_busy_off", 32'(clear_busy), 32'd0);
            check_val("t5_gnt_after", 32'(gnt), 32'b001);
            check_val("t5_sb_empty", 32'(exp_q.size()), 32'd0);
            step();
            check_val("t5_done_pulse", 32'(clear_done), 32'd0);
            req = 3'b000;
            step();
            step();
        end

        // Reset asserted while the 100th sweep write is on M2.
        clear_bank = 1'b0;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int b = 0; b < BINS; b++) push_exp(ADDR_W'(b), 20'd0);
        for (int i = 0; i < 101; i++) step();
        check_val("t6_popped", 32'(BINS - exp_q.size()), 32'd99);
        check_val("t6_addr100", 32'(M2_WriteAddress), 32'd99);
        reset = 1'b1;
        #1;
        check_val("t6_we", 32'(M2_WriteEnable), 32'd0);
        check_val("t6_addr", 32'(M2_WriteAddress), 32'd0);
        check_val("t6_busy", 32'(clear_busy), 32'd0);
        do_reset();
        for (int i = 0; i < 20; i++) step();
        check_val("t6_no_writes", 32'(M2_WriteEnable), 32'd0);
        check_val("t6_busy_after", 32'(clear_busy), 32'd0);
`else
        // Without the sweep engine a clear request has no effect.
        clear_bank = 1'b1;
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("noclr_busy", 32'(clear_busy), 32'd0);
            check_val("noclr_done", 32'(clear_done), 32'd0);
            check_val("noclr_we", 32'(M2_WriteEnable), 32'd0);
        end
`endif

        check_val("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
